// File: rtl/imem_loader.sv
// Byte-stream program loader: turns a framed stream (count, high/low instruction bytes, XOR checksum)
// into 16-bit instruction memory writes and holds the core in reset until a load succeeds.
module imem_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                CHECK_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, CNT, HI, LO, CHK} state_t;

  state_t            state;
  state_t            state_next;
  logic [8:0]        remaining;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi;
  logic [7:0]        chk;
  logic              accept;
  logic              last_word;

  assign accept    = in_valid & in_ready;
  assign last_word = (remaining == 9'd1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Every non-IDLE state consumes exactly one byte; a missing in_valid simply holds the state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: if (start) state_next = CNT;
      CNT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = HI;
      end
      HI: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LO;
      end
      LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!last_word)    state_next = HI;
          else if (CHECK_EN) state_next = CHK;
          else               state_next = IDLE;
        end
      end
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining  <= '0;
      addr       <= '0;
      hi         <= '0;
      chk        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done    <= 1'b0;
            err     <= 1'b0;
            cpu_rst <= 1'b1;
          end
        end
        CNT: begin
          if (accept) begin
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            addr      <= BASE_ADDR;
            chk       <= '0;
          end
        end
        HI: begin
          if (accept) begin
            hi  <= in_data;
            chk <= chk ^ in_data;
          end
        end
        LO: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= {hi, in_data};
            chk        <= chk ^ in_data;
            addr       <= addr + 1'b1;
            remaining  <= remaining - 9'd1;
            // Without a checksum byte the last word itself completes the load.
            if (last_word && !CHECK_EN) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end
          end
        end
        CHK: begin
          if (accept) begin
            if (in_data == chk) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a queue-based
// model of expected memory writes, checksum outcome and status flags.
module tb_imem_loader;

  localparam logic [7:0] BASE = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_rst, busy, done, err;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;

  logic        start0, in_valid0;
  logic [7:0]  in_data0;
  logic        in_ready0, imem_we0, cpu_rst0, busy0, done0, err0;
  logic [7:0]  imem_addr0;
  logic [15:0] imem_wdata0;

  int checks = 0;
  int errors = 0;
  logic [15:0] frame_words[$];
  logic [23:0] exp_q[$];
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE), .CHECK_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(in_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
    .cpu_rst(cpu_rst0), .busy(busy0), .done(done0), .err(err0)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected {addr, data} and never last two cycles.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      check_output("we_single_cycle", {31'd0, prev_we}, 32'd0);
      check_output("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check_output("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
    prev_we = imem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit pulse_start);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = pulse_start;
    check_output("in_ready_busy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Sends frame_words as one frame; chk_sel < 0 sends the correct checksum, else that byte.
  task automatic apply_stimulus(input logic [7:0] cnt, input int chk_sel, input int max_gap,
                                input bit start_mid);
    int         n;
    logic [7:0] sum;
    logic [7:0] chk_byte;
    bit         ok;
    n   = (cnt == 8'd0) ? 256 : int'(cnt);
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      sum ^= frame_words[i][15:8] ^ frame_words[i][7:0];
      exp_q.push_back({8'(int'(BASE) + i), frame_words[i]});
    end
    chk_byte = (chk_sel < 0) ? sum : 8'(chk_sel);
    ok       = (chk_byte == sum);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("start_busy", {31'd0, busy}, 32'd1);
    check_output("start_done_clr", {31'd0, done}, 32'd0);
    check_output("start_err_clr", {31'd0, err}, 32'd0);
    check_output("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    send_byte(cnt, max_gap, 1'b0);
    for (int i = 0; i < n; i++) begin
      send_byte(frame_words[i][15:8], max_gap, start_mid);
      send_byte(frame_words[i][7:0], max_gap, start_mid);
    end
    send_byte(chk_byte, max_gap, start_mid);
    check_output("end_done", {31'd0, done}, {31'd0, ok});
    check_output("end_err", {31'd0, err}, {31'd0, !ok});
    check_output("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, !ok});
    check_output("end_busy", {31'd0, busy}, 32'd0);
    check_output("end_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("end_writes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    start0 = 1'b0; in_valid0 = 1'b0; in_data0 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset values");
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check_output("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    check_output("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
    check_output("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_err", {31'd0, err}, 32'd0);
    check_output("rst0_cpu_rst", {31'd0, cpu_rst0}, 32'd1);

    $display("[TB] in_valid while idle");
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    check_output("idle_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("idle_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;

    $display("[TB] good frame");
    frame_words = {16'hF00A, 16'hF21E};
    apply_stimulus(8'h02, 'h16, 0, 1'b0);

    $display("[TB] bad checksum");
    apply_stimulus(8'h02, 'h17, 0, 1'b0);

    $display("[TB] good frame with gaps");
    apply_stimulus(8'h02, -1, 3, 1'b0);

    $display("[TB] count 0, 256 words");
    frame_words.delete();
    for (int k = 0; k < 256; k++) frame_words.push_back({8'(k), ~8'(k)});
    apply_stimulus(8'h00, -1, 0, 1'b0);

    $display("[TB] reset mid-load");
    frame_words = {16'hF00A, 16'hF21E};
    exp_q.push_back({BASE, 16'hF00A});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'hF0, 0, 1'b0);
    send_byte(8'h0A, 0, 1'b0);
    send_byte(8'hF2, 0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h1E;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_output("mid_rst_imem_we", {31'd0, imem_we}, 32'd0);
    check_output("mid_rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    check_output("mid_rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
    check_output("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_output("mid_rst_done", {31'd0, done}, 32'd0);
    check_output("mid_rst_err", {31'd0, err}, 32'd0);
    check_output("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check_output("mid_rst_no_2nd_write", exp_q.size(), 32'd0);
    apply_stimulus(8'h02, -1, 0, 1'b0);

    $display("[TB] start pulsed during load");
    apply_stimulus(8'h02, -1, 1, 1'b1);

    $display("[TB] random frames");
    for (int f = 0; f < 5; f++) begin
      int cnt;
      int sel;
      cnt = int'($urandom_range(12, 1));
      frame_words.delete();
      for (int k = 0; k < cnt; k++) frame_words.push_back(16'($urandom()));
      sel = ($urandom_range(1, 0) == 1) ? -1 : int'($urandom_range(255, 0));
      apply_stimulus(8'(cnt), sel, 3, 1'($urandom_range(1, 0)));
    end

    $display("[TB] no-checksum variant");
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 8'h01;
    @(negedge clk);
    in_data0 = 8'hD0;
    @(negedge clk);
    in_data0 = 8'h05;
    @(negedge clk);
    in_valid0 = 1'b0;
    check_output("nochk_we", {31'd0, imem_we0}, 32'd1);
    check_output("nochk_addr", {24'd0, imem_addr0}, {24'd0, BASE});
    check_output("nochk_wdata", {16'd0, imem_wdata0}, 32'hD005);
    check_output("nochk_done", {31'd0, done0}, 32'd1);
    check_output("nochk_err", {31'd0, err0}, 32'd0);
    check_output("nochk_cpu_rst", {31'd0, cpu_rst0}, 32'd0);
    check_output("nochk_in_ready", {31'd0, in_ready0}, 32'd0);
    check_output("nochk_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    check_output("nochk_we_drop", {31'd0, imem_we0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
